// File: rtl/alu_pkg.sv
// Shared types for the stream reduction ALU: operation select and FSM state encodings.
package alu_pkg;

   typedef enum logic [1:0] {
      OpAdd = 2'd0,
      OpMul = 2'd1,
      OpMax = 2'd2,
      OpXor = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRecv = 2'd1,
      StExec = 2'd2,
      StDone = 2'd3
   } state_e;

   function automatic int unsigned bytes_per_opnd(input int unsigned width);
      return width / 8;
   endfunction

endpackage

// File: rtl/stream_reduce_alu_if.sv
// Control, byte-stream and result bundle between a reduction client and stream_reduce_alu.
interface stream_reduce_alu_if
   import alu_pkg::*;
#(
   parameter int unsigned datawidth_p = 32,
   parameter int unsigned lenwidth_p  = 16
);

   logic                   start_i;
   op_e                    op_i;
   logic [lenwidth_p-1:0]  len_i;
   logic                   valid_i;
   logic [7:0]             data_i;
   logic                   ready_o;
   logic                   busy_o;
   logic                   done_o;
   logic [datawidth_p-1:0] result_o;
   logic                   overflow_o;

   modport slave (
      input  start_i, op_i, len_i, valid_i, data_i,
      output ready_o, busy_o, done_o, result_o, overflow_o
   );

   modport master (
      output start_i, op_i, len_i, valid_i, data_i,
      input  ready_o, busy_o, done_o, result_o, overflow_o
   );

endinterface

// File: rtl/iter_mul.sv
// Shift-add unsigned multiplier: one partial product per cycle, full 2W-bit product.
// The load cycle already folds in multiplier bit 0, so v_o pulses width_p cycles after v_i.
module iter_mul #(
   parameter int unsigned width_p = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   v_i,
   input  logic [width_p-1:0]     a_i,
   input  logic [width_p-1:0]     b_i,
   output logic                   ready_o,
   output logic                   v_o,
   output logic [2*width_p-1:0]   product_o
);

   localparam int unsigned PW   = 2 * width_p;
   localparam int unsigned CntW = $clog2(width_p + 1);

   logic [PW-1:0]      mcand_q, mcand_d;
   logic [PW-1:0]      prod_q, prod_d;
   logic [width_p-1:0] mplier_q, mplier_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               idle_q;
   logic               v_q, v_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      v_d      = 1'b0;
      if (busy_q) begin
         if (mplier_q[0]) prod_d = prod_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CntW'(1);
         if (cnt_q == CntW'(width_p - 1)) begin
            busy_d = 1'b0;
            v_d    = 1'b1;
         end
      end else if (v_i) begin
         prod_d   = b_i[0] ? PW'(a_i) : '0;
         mcand_d  = PW'(a_i) << 1;
         mplier_d = b_i >> 1;
         cnt_d    = CntW'(1);
         busy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         idle_q   <= 1'b1;
         v_q      <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         idle_q   <= ~busy_d;
         v_q      <= v_d;
      end
   end

   assign ready_o   = idle_q;
   assign v_o       = v_q;
   assign product_o = prod_q;

endmodule

// File: rtl/stream_reduce_alu.sv
// Multi-operand reduction unit: gathers MSB-first operand bytes and folds them with ADD/MUL/MAX/XOR.
// The multiplier is launched on the last byte handshake so a MUL step occupies exactly datawidth_p exec cycles.
module stream_reduce_alu
   import alu_pkg::*;
#(
   parameter int unsigned datawidth_p = 32,
   parameter int unsigned lenwidth_p  = 16
) (
   input logic                clk_i,
   input logic                rst_ni,
   stream_reduce_alu_if.slave bus
);

   localparam int unsigned W   = datawidth_p;
   localparam int unsigned L   = lenwidth_p;
   localparam int unsigned PW  = 2 * W;
   localparam int unsigned NB  = bytes_per_opnd(W);
   localparam int unsigned BcW = (NB > 1) ? $clog2(NB) : 1;

   state_e        state_q, state_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   op_e           op_q, op_d;
   logic [L-1:0]  rem_q, rem_d;
   logic [BcW-1:0] bcnt_q, bcnt_d;
   logic [W-1:0]  opnd_q, opnd_d;
   logic [W-1:0]  acc_q, acc_d;
   logic          ovf_q, ovf_d;
   logic          first_q, first_d;

   logic          hs;
   logic          last_byte;
   logic [W-1:0]  opnd_shift;
   logic [W:0]    add_sum;
   logic          exec_done;
   logic          mul_v_i;
   logic          mul_ready;
   logic          mul_v;
   logic [PW-1:0] mul_prod;

   assign hs         = bus.valid_i & ready_q;
   assign last_byte  = (bcnt_q == BcW'(NB - 1));
   assign opnd_shift = W'({opnd_q, bus.data_i});
   assign add_sum    = {1'b0, acc_q} + {1'b0, opnd_q};
   assign mul_v_i    = hs & last_byte & (op_q == OpMul) & ~first_q & mul_ready;
   assign exec_done  = first_q | (op_q != OpMul) | mul_v;

   iter_mul #(.width_p(W)) u_iter_mul (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .v_i       (mul_v_i),
      .a_i       (acc_q),
      .b_i       (opnd_shift),
      .ready_o   (mul_ready),
      .v_o       (mul_v),
      .product_o (mul_prod)
   );

   // FSM state and registered status outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (bus.start_i) state_d = (bus.len_i == '0) ? StDone : StRecv;
         StRecv: if (hs && last_byte) state_d = StExec;
         StExec: if (exec_done) state_d = (rem_q == L'(1)) ? StDone : StRecv;
         StDone: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ready_d = (state_d == StRecv);
      busy_d  = (state_d != StIdle);
      done_d  = (state_d == StDone);
   end

   // Operand shifter, counters, accumulator and sticky overflow
   always_comb begin
      op_d    = op_q;
      rem_d   = rem_q;
      bcnt_d  = bcnt_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      first_d = first_q;
      case (state_q)
         StIdle: begin
            if (bus.start_i) begin
               op_d    = bus.op_i;
               rem_d   = bus.len_i;
               bcnt_d  = '0;
               opnd_d  = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
               first_d = 1'b1;
            end
         end
         StRecv: begin
            if (hs) begin
               opnd_d = opnd_shift;
               bcnt_d = last_byte ? '0 : bcnt_q + BcW'(1);
            end
         end
         StExec: begin
            if (exec_done) begin
               first_d = 1'b0;
               rem_d   = rem_q - L'(1);
               if (first_q) begin
                  acc_d = opnd_q;
               end else begin
                  case (op_q)
                     OpAdd: begin
                        acc_d = add_sum[W-1:0];
                        ovf_d = ovf_q | add_sum[W];
                     end
                     OpMul: begin
                        acc_d = mul_prod[W-1:0];
                        ovf_d = ovf_q | (|mul_prod[PW-1:W]);
                     end
                     OpMax:   acc_d = (opnd_q > acc_q) ? opnd_q : acc_q;
                     default: acc_d = acc_q ^ opnd_q;
                  endcase
               end
            end
         end
         StDone: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q    <= OpAdd;
         rem_q   <= '0;
         bcnt_q  <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         op_q    <= op_d;
         rem_q   <= rem_d;
         bcnt_q  <= bcnt_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         first_q <= first_d;
      end
   end

   assign bus.ready_o    = ready_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.result_o   = acc_q;
   assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_stream_reduce_alu.sv
// Scoreboard bench for stream_reduce_alu: a 32-bit and a 16-bit instance share one stimulus driver.
module tb_stream_reduce_alu;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        sel16;
   logic        start;
   logic        valid;
   op_e         op;
   logic [15:0] len;
   logic [7:0]  data;

   logic        ready, busy, done, ovf;
   logic [31:0] result;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb[$];
   logic [31:0] ops_q[$];

   stream_reduce_alu_if #(.datawidth_p(32), .lenwidth_p(16)) bus32 ();
   stream_reduce_alu_if #(.datawidth_p(16), .lenwidth_p(16)) bus16 ();

   stream_reduce_alu #(.datawidth_p(32), .lenwidth_p(16)) u_dut32 (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus32)
   );
   stream_reduce_alu #(.datawidth_p(16), .lenwidth_p(16)) u_dut16 (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus16)
   );

   assign bus32.start_i = start & ~sel16;
   assign bus16.start_i = start & sel16;
   assign bus32.valid_i = valid & ~sel16;
   assign bus16.valid_i = valid & sel16;
   assign bus32.op_i    = op;
   assign bus16.op_i    = op;
   assign bus32.len_i   = len;
   assign bus16.len_i   = len;
   assign bus32.data_i  = data;
   assign bus16.data_i  = data;

   assign ready  = sel16 ? bus16.ready_o    : bus32.ready_o;
   assign busy   = sel16 ? bus16.busy_o     : bus32.busy_o;
   assign done   = sel16 ? bus16.done_o     : bus32.done_o;
   assign ovf    = sel16 ? bus16.overflow_o : bus32.overflow_o;
   assign result = sel16 ? {16'h0, bus16.result_o} : bus32.result_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input op_e o, input int w);
      exp_t        e;
      logic [63:0] acc, t, mask, x;
      mask  = (64'd1 << w) - 64'd1;
      e.ovf = 1'b0;
      acc   = '0;
      if (ops_q.size() > 0) acc = {32'd0, ops_q[0]} & mask;
      for (int k = 1; k < ops_q.size(); k++) begin
         x = {32'd0, ops_q[k]} & mask;
         case (o)
            OpAdd: begin t = acc + x; if (t > mask) e.ovf = 1'b1; acc = t & mask; end
            OpMul: begin t = acc * x; if (t > mask) e.ovf = 1'b1; acc = t & mask; end
            OpMax: if (x > acc) acc = x;
            default: acc = acc ^ x;
         endcase
      end
      e.res = acc[31:0];
      return e;
   endfunction

   task automatic start_run(input bit s16, input op_e o);
      sel16 = s16;
      sb.push_back(model(o, s16 ? 16 : 32));
      op    = o;
      len   = 16'(ops_q.size());
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed_ops(input bit gap);
      int nb;
      int n;
      nb = sel16 ? 2 : 4;
      foreach (ops_q[k]) begin
         for (int b = nb - 1; b >= 0; b--) begin
            if (gap) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            valid = 1'b1;
            data  = 8'(ops_q[k] >> (8 * b));
            n = 0;
            while (!ready && n < 100) begin @(posedge clk); #1; n++; end
            if (n >= 100) begin
               checks++; failures++;
               $display("FAIL handshake_timeout got ready=%b want ready=1", ready);
            end
            @(posedge clk); #1;
            valid = 1'b0;
         end
      end
   endtask

   // Cycles from the last handshake cycle to the cycle in which done_o is seen high
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         sel16 = (s == 1); #1;
         checks++; if (ready !== 1'b0)   begin failures++; $display("FAIL reset.ready dut%0d got=%b want=0", s, ready); end
         checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset.busy dut%0d got=%b want=0", s, busy); end
         checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset.done dut%0d got=%b want=0", s, done); end
         checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset.result dut%0d got=%h want=0", s, result); end
         checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL reset.ovf dut%0d got=%b want=0", s, ovf); end
      end
      sel16 = 1'b0;
   endtask

   task automatic test_mul_chain();
      exp_t e; int lat;
      ops_q = '{32'd2, 32'd3, 32'd7};
      start_run(1'b0, OpMul); feed_ops(1'b0); wait_done(lat);
      e = sb.pop_front();
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL mul_chain.done got=%b want=1", done); end
      checks++; if (result !== e.res)  begin failures++; $display("FAIL mul_chain.result got=%h want=%h", result, e.res); end
      checks++; if (ovf !== e.ovf)     begin failures++; $display("FAIL mul_chain.ovf got=%b want=%b", ovf, e.ovf); end
      checks++; if (lat != 33)         begin failures++; $display("FAIL mul_chain.latency got=%0d want=33", lat); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL mul_chain.pulse got=%b want=0", done); end
      checks++; if (result !== e.res)  begin failures++; $display("FAIL mul_chain.hold got=%h want=%h", result, e.res); end
   endtask

   task automatic test_add_carry();
      exp_t e; int lat;
      ops_q = '{32'hFFFF_FFFF, 32'h2};
      start_run(1'b0, OpAdd); feed_ops(1'b0); wait_done(lat);
      e = sb.pop_front();
      checks++; if (result !== e.res)  begin failures++; $display("FAIL add_carry.result got=%h want=%h", result, e.res); end
      checks++; if (ovf !== e.ovf)     begin failures++; $display("FAIL add_carry.ovf got=%b want=%b", ovf, e.ovf); end
      checks++; if (lat != 2)          begin failures++; $display("FAIL add_carry.latency got=%0d want=2", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_max_gapped();
      exp_t e; int lat;
      ops_q = '{32'h5, 32'h8000, 32'h3, 32'h7FFF};
      start_run(1'b1, OpMax); feed_ops(1'b1); wait_done(lat);
      e = sb.pop_front();
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL max_gapped.done got=%b want=1", done); end
      checks++; if (result !== e.res)  begin failures++; $display("FAIL max_gapped.result got=%h want=%h", result, e.res); end
      checks++; if (ovf !== e.ovf)     begin failures++; $display("FAIL max_gapped.ovf got=%b want=%b", ovf, e.ovf); end
      checks++; if (lat != 2)          begin failures++; $display("FAIL max_gapped.latency got=%0d want=2", lat); end
      @(posedge clk); #1;
      sel16 = 1'b0;
   endtask

   task automatic test_len_zero();
      exp_t e;
      ops_q = {};
      start_run(1'b0, OpMul);
      e = sb.pop_front();
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL len_zero.done got=%b want=1", done); end
      checks++; if (result !== e.res)  begin failures++; $display("FAIL len_zero.result got=%h want=%h", result, e.res); end
      checks++; if (ovf !== e.ovf)     begin failures++; $display("FAIL len_zero.ovf got=%b want=%b", ovf, e.ovf); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL len_zero.pulse got=%b want=0", done); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL len_zero.busy got=%b want=0", busy); end
   endtask

   task automatic test_start_ignored();
      exp_t e; int lat;
      ops_q = '{32'd6, 32'd7};
      start_run(1'b0, OpMul); feed_ops(1'b0);
      op = OpXor; len = 16'd0; start = 1'b1;
      repeat (3) begin
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_ignored.busy got=%b want=1", busy); end
         @(posedge clk); #1;
      end
      start = 1'b0;
      lat = 4;
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
      e = sb.pop_front();
      checks++; if (result !== e.res)  begin failures++; $display("FAIL start_ignored.result got=%h want=%h", result, e.res); end
      checks++; if (lat != 33)         begin failures++; $display("FAIL start_ignored.latency got=%0d want=33", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_mul_overflow();
      exp_t e; int lat;
      ops_q = '{32'h0001_0000, 32'h0001_0000};
      start_run(1'b0, OpMul); feed_ops(1'b0); wait_done(lat);
      e = sb.pop_front();
      checks++; if (result !== e.res)  begin failures++; $display("FAIL mul_ovf.result got=%h want=%h", result, e.res); end
      checks++; if (ovf !== e.ovf)     begin failures++; $display("FAIL mul_ovf.ovf got=%b want=%b", ovf, e.ovf); end
      checks++; if (lat != 33)         begin failures++; $display("FAIL mul_ovf.latency got=%0d want=33", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_len_one();
      exp_t e; int lat;
      ops_q = '{32'hDEAD_BEEF};
      start_run(1'b0, OpAdd); feed_ops(1'b0); wait_done(lat);
      e = sb.pop_front();
      checks++; if (result !== e.res)  begin failures++; $display("FAIL len_one.result got=%h want=%h", result, e.res); end
      checks++; if (ovf !== e.ovf)     begin failures++; $display("FAIL len_one.ovf got=%b want=%b", ovf, e.ovf); end
      checks++; if (lat != 2)          begin failures++; $display("FAIL len_one.latency got=%0d want=2", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_then_xor();
      exp_t e; int lat;
      ops_q = '{32'h1234_5678, 32'h9};
      start_run(1'b0, OpMul); feed_ops(1'b0);
      repeat (5) begin @(posedge clk); #1; end
      e = sb.pop_front();
      rst_n = 1'b0; #1;
      checks++; if (ready !== 1'b0)   begin failures++; $display("FAIL reset_mid.ready got=%b want=0", ready); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_mid.busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_mid.done got=%b want=0", done); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_mid.result got=%h want=0", result); end
      checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL reset_mid.ovf got=%b want=0", ovf); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      ops_q = '{32'hA5A5_A5A5, 32'h0F0F_0F0F};
      start_run(1'b0, OpXor); feed_ops(1'b0); wait_done(lat);
      e = sb.pop_front();
      checks++; if (result !== e.res) begin failures++; $display("FAIL xor.result got=%h want=%h", result, e.res); end
      checks++; if (result !== 32'hAAAA_AAAA) begin failures++; $display("FAIL xor.const got=%h want=aaaaaaaa", result); end
      checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL xor.ovf got=%b want=0", ovf); end
      checks++; if (lat != 2)         begin failures++; $display("FAIL xor.latency got=%0d want=2", lat); end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      sel16 = 1'b0;
      start = 1'b0;
      valid = 1'b0;
      op    = OpAdd;
      len   = '0;
      data  = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      test_mul_chain();
      test_add_carry();
      test_max_gapped();
      test_len_zero();
      test_start_ignored();
      test_mul_overflow();
      test_len_one();
      test_reset_mid_then_xor();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
